// File: rtl/jam_pkg.sv
// Shared types and helpers for the exhaustive job-assignment engine.
package jam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_QUERY = 2'd1,
        ST_EVAL  = 2'd2,
        ST_DONE  = 2'd3
    } jam_state_e;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    localparam int N_MIN = 32'sd2;
    localparam int N_MAX = 32'sd8;

    function automatic bit n_is_legal(input int n);
        return (n >= N_MIN) && (n <= N_MAX);
    endfunction

    // An index must be at least one bit wide even when N = 2.
    function automatic int idx_width(input int n);
        return (n > 32'sd2) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/jam_next_perm.sv
// Combinational lexicographic successor of a packed permutation.
module jam_next_perm #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N*IW-1:0] perm,
    output logic [N*IW-1:0] next_perm,
    output logic            is_last
);

    logic [IW-1:0]   p_s [N];
    logic [IW-1:0]   q_s [N];
    logic [IW-1:0]   piv_s;
    logic [IW-1:0]   succ_s;
    logic [IW-1:0]   ridx_s;
    logic            found_s;
    logic [N*IW-1:0] nxt_s;

    // Pivot search, swap with the smallest larger suffix element, suffix reversal.
    always_comb begin
        found_s = 1'b0;
        piv_s   = {IW{1'b0}};
        succ_s  = {IW{1'b0}};
        ridx_s  = {IW{1'b0}};
        nxt_s   = {(N*IW){1'b0}};
        for (int i = 0; i < N; i++) begin
            p_s[i] = perm[i*IW +: IW];
        end
        for (int i = 0; i < N - 1; i++) begin
            found_s = found_s | (p_s[i] < p_s[i+1]);
            piv_s   = (p_s[i] < p_s[i+1]) ? IW'(i) : piv_s;
        end
        // The suffix is descending, so the rightmost larger element is the smallest one.
        for (int i = 0; i < N; i++) begin
            succ_s = ((IW'(i) > piv_s) && (p_s[i] > p_s[piv_s])) ? IW'(i) : succ_s;
        end
        q_s         = p_s;
        q_s[piv_s]  = p_s[succ_s];
        q_s[succ_s] = p_s[piv_s];
        for (int i = 0; i < N; i++) begin
            ridx_s = IW'(N - 1) + piv_s + IW'(1) - IW'(i);
            nxt_s[i*IW +: IW] = (IW'(i) > piv_s) ? q_s[ridx_s] : q_s[i];
        end
        is_last   = ~found_s;
        next_perm = found_s ? nxt_s : perm;
    end

endmodule

// File: rtl/jam_param.sv
// Exhaustive N! job-assignment search with min/max mode and Start/Busy handshake.
module jam_param
    import jam_pkg::*;
#(
    parameter int N  = 8,
    parameter int CW = 7,
    parameter int IW = idx_width(N),
    parameter int SW = CW + IW,
    parameter int MW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Start,
    input  logic            Mode,
    output logic [IW-1:0]   W,
    output logic [IW-1:0]   J,
    input  logic [CW-1:0]   Cost,
    output logic            Busy,
    output logic            Valid,
    output logic [SW-1:0]   BestCost,
    output logic [MW-1:0]   MatchCount,
    output logic [N*IW-1:0] BestPerm
);

    if (!n_is_legal(N)) begin : g_bad_n
        $error("jam_param: N must lie in 2..8");
    end

    function automatic logic [N*IW-1:0] identity_perm();
        logic [N*IW-1:0] v;
        v = {(N*IW){1'b0}};
        for (int i = 0; i < N; i++) begin
            v[i*IW +: IW] = IW'(i);
        end
        return v;
    endfunction

    localparam logic [N*IW-1:0] IDENT   = identity_perm();
    localparam logic [MW-1:0]   CNT_MAX = {MW{1'b1}};

    jam_state_e      state_r, state_s;
    logic [N*IW-1:0] perm_r, perm_s, bperm_r, bperm_s, next_perm_s;
    logic [IW-1:0]   w_r, w_s, j_r, j_s, w_inc_s;
    logic [IW-1:0]   perm_a [N];
    logic [SW-1:0]   sum_r, sum_s, best_r, best_s;
    logic [MW-1:0]   cnt_r, cnt_s;
    logic            mode_r, mode_s, busy_r, busy_s, valid_r, valid_s;
    logic            better_s, is_last_s;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign perm_a[g] = perm_r[g*IW +: IW];
    end

    jam_next_perm #(.N(N), .IW(IW)) u_next_perm (
        .perm      (perm_r),
        .next_perm (next_perm_s),
        .is_last   (is_last_s)
    );

    // Next-state and next-value logic for the search FSM and its datapath.
    always_comb begin
        state_s  = state_r;
        perm_s   = perm_r;
        w_s      = w_r;
        j_s      = j_r;
        sum_s    = sum_r;
        mode_s   = mode_r;
        best_s   = best_r;
        cnt_s    = cnt_r;
        bperm_s  = bperm_r;
        better_s = 1'b0;
        w_inc_s  = w_r + IW'(1);
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (Start) begin
                    state_s = ST_QUERY;
                    perm_s  = IDENT;
                    w_s     = {IW{1'b0}};
                    j_s     = {IW{1'b0}};
                    sum_s   = {SW{1'b0}};
                    mode_s  = Mode;
                    best_s  = (Mode == MODE_MIN) ? {SW{1'b1}} : {SW{1'b0}};
                    cnt_s   = {MW{1'b0}};
                    bperm_s = IDENT;
                end else begin
                    state_s = state_r;
                end
            end
            ST_QUERY: begin
                sum_s = sum_r + SW'(Cost);
                if (w_r == IW'(N - 1)) begin
                    state_s = ST_EVAL;
                    w_s     = {IW{1'b0}};
                    j_s     = perm_a[0];
                end else begin
                    w_s = w_inc_s;
                    j_s = perm_a[w_inc_s];
                end
            end
            ST_EVAL: begin
                better_s = (mode_r == MODE_MAX) ? (sum_r > best_r) : (sum_r < best_r);
                if (better_s) begin
                    best_s  = sum_r;
                    cnt_s   = MW'(1);
                    bperm_s = perm_r;
                end else if (sum_r == best_r) begin
                    cnt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + MW'(1);
                end else begin
                    cnt_s = cnt_r;
                end
                sum_s = {SW{1'b0}};
                w_s   = {IW{1'b0}};
                // The last permutation is left in place so J keeps showing perm[0].
                if (is_last_s) begin
                    state_s = ST_DONE;
                    j_s     = perm_a[0];
                end else begin
                    state_s = ST_QUERY;
                    perm_s  = next_perm_s;
                    j_s     = next_perm_s[IW-1:0];
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s  = (state_s == ST_QUERY) || (state_s == ST_EVAL);
        valid_s = (state_s == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            perm_r  <= IDENT;
            w_r     <= {IW{1'b0}};
            j_r     <= {IW{1'b0}};
            sum_r   <= {SW{1'b0}};
            mode_r  <= MODE_MIN;
            best_r  <= {SW{1'b1}};
            cnt_r   <= {MW{1'b0}};
            bperm_r <= IDENT;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            perm_r  <= perm_s;
            w_r     <= w_s;
            j_r     <= j_s;
            sum_r   <= sum_s;
            mode_r  <= mode_s;
            best_r  <= best_s;
            cnt_r   <= cnt_s;
            bperm_r <= bperm_s;
            busy_r  <= busy_s;
            valid_r <= valid_s;
        end
    end

    assign W          = w_r;
    assign J          = j_r;
    assign Busy       = busy_r;
    assign Valid      = valid_r;
    assign BestCost   = best_r;
    assign MatchCount = cnt_r;
    assign BestPerm   = bperm_r;

endmodule

// File: tb/tb_jam_param.sv
// Randomised self-checking bench: three jam_param instances (N=2, N=3, N=4 with narrow MatchCount)
// compared against a brute-force tuple-enumeration reference model.
module tb_jam_param;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic rst [3];
    logic start [3];
    logic mode [3];

    logic [6:0] tab [3][8][8];

    int nn  [3] = '{2, 3, 4};
    int iww [3] = '{1, 2, 2};
    int sww [3] = '{8, 9, 9};
    int mww [3] = '{16, 16, 4};

    // u2: N=2
    logic [0:0] w2, j2;
    logic [6:0] cost2;
    logic       busy2, valid2;
    logic [7:0] best2;
    logic [15:0] cnt2;
    logic [1:0] perm2;
    // u3: N=3
    logic [1:0] w3, j3;
    logic [6:0] cost3;
    logic       busy3, valid3;
    logic [8:0] best3;
    logic [15:0] cnt3;
    logic [5:0] perm3;
    // u4: N=4, MW=4
    logic [1:0] w4, j4;
    logic [6:0] cost4;
    logic       busy4, valid4;
    logic [8:0] best4;
    logic [3:0] cnt4;
    logic [7:0] perm4;

    assign cost2 = tab[0][w2][j2];
    assign cost3 = tab[1][w3][j3];
    assign cost4 = tab[2][w4][j4];

    jam_param #(.N(2)) u2 (
        .CLK(CLK), .RST(rst[0]), .Start(start[0]), .Mode(mode[0]), .W(w2), .J(j2), .Cost(cost2),
        .Busy(busy2), .Valid(valid2), .BestCost(best2), .MatchCount(cnt2), .BestPerm(perm2)
    );
    jam_param #(.N(3)) u3 (
        .CLK(CLK), .RST(rst[1]), .Start(start[1]), .Mode(mode[1]), .W(w3), .J(j3), .Cost(cost3),
        .Busy(busy3), .Valid(valid3), .BestCost(best3), .MatchCount(cnt3), .BestPerm(perm3)
    );
    jam_param #(.N(4), .MW(4)) u4 (
        .CLK(CLK), .RST(rst[2]), .Start(start[2]), .Mode(mode[2]), .W(w4), .J(j4), .Cost(cost4),
        .Busy(busy4), .Valid(valid4), .BestCost(best4), .MatchCount(cnt4), .BestPerm(perm4)
    );

    logic        busy_v [3], valid_v [3];
    int          best_v [3], cnt_v [3], w_v [3], j_v [3];
    logic [15:0] perm_v [3];

    assign busy_v[0] = busy2;  assign busy_v[1] = busy3;  assign busy_v[2] = busy4;
    assign valid_v[0] = valid2; assign valid_v[1] = valid3; assign valid_v[2] = valid4;
    assign best_v[0] = int'(best2); assign best_v[1] = int'(best3); assign best_v[2] = int'(best4);
    assign cnt_v[0] = int'(cnt2); assign cnt_v[1] = int'(cnt3); assign cnt_v[2] = int'(cnt4);
    assign w_v[0] = int'(w2); assign w_v[1] = int'(w3); assign w_v[2] = int'(w4);
    assign j_v[0] = int'(j2); assign j_v[1] = int'(j3); assign j_v[2] = int'(j4);
    assign perm_v[0] = 16'(perm2); assign perm_v[1] = 16'(perm3); assign perm_v[2] = 16'(perm4);

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] ident(input int u);
        logic [15:0] v;
        v = 16'd0;
        for (int k = 0; k < nn[u]; k++) begin
            v = v | (16'(k) << (k * iww[u]));
        end
        return v;
    endfunction

    // Reference: walk every n-digit base-n tuple in ascending order (which is lexicographic),
    // keep those with distinct digits, and track the best total, tie count and first optimum.
    task automatic model(input int u, input bit mx, output int eb, output int ec, output logic [15:0] ep);
        int n, total, c, s;
        int d [8];
        bit seen [8];
        bit ok;
        n  = nn[u];
        eb = mx ? 0 : (1 << sww[u]) - 1;
        ec = 0;
        ep = ident(u);
        total = 1;
        for (int k = 0; k < n; k++) total = total * n;
        for (int code = 0; code < total; code++) begin
            c = code;
            for (int k = n - 1; k >= 0; k--) begin
                d[k] = c % n;
                c = c / n;
            end
            ok = 1'b1;
            for (int k = 0; k < 8; k++) seen[k] = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (seen[d[k]]) ok = 1'b0;
                seen[d[k]] = 1'b1;
            end
            if (ok) begin
                s = 0;
                for (int k = 0; k < n; k++) s = s + int'(tab[u][k][d[k]]);
                if (mx ? (s > eb) : (s < eb)) begin
                    eb = s;
                    ec = 1;
                    ep = 16'd0;
                    for (int k = 0; k < n; k++) ep = ep | (16'(d[k]) << (k * iww[u]));
                end else if (s == eb && ec < (1 << mww[u]) - 1) begin
                    ec++;
                end
            end
        end
    endtask

    task automatic chk_reset(input int u, input string tag);
        chk({tag, " busy"},  int'(busy_v[u]), 0);
        chk({tag, " valid"}, int'(valid_v[u]), 0);
        chk({tag, " best"},  best_v[u], (1 << sww[u]) - 1);
        chk({tag, " count"}, cnt_v[u], 0);
        chk({tag, " perm"},  int'(perm_v[u]), int'(ident(u)));
        chk({tag, " W"},     w_v[u], 0);
        chk({tag, " J"},     j_v[u], 0);
    endtask

    // Launch one search, optionally pulse Start again mid-run, and check latency and results.
    task automatic run(input int u, input bit mx, input int mid, input string tag);
        int fact, lim, cyc, eb, ec;
        logic [15:0] ep;
        fact = 1;
        for (int k = 2; k <= nn[u]; k++) fact = fact * k;
        lim = fact * (nn[u] + 1);
        mode[u]  = mx;
        start[u] = 1'b1;
        tick();
        start[u] = 1'b0;
        mode[u]  = ~mx;
        chk({tag, " busy at start"}, int'(busy_v[u]), 1);
        chk({tag, " valid at start"}, int'(valid_v[u]), 0);
        cyc = 0;
        while (!valid_v[u] && cyc < lim + 20) begin
            if (cyc == mid) start[u] = 1'b1;
            tick();
            start[u] = 1'b0;
            cyc++;
        end
        chk({tag, " latency"}, cyc, lim);
        chk({tag, " busy at done"}, int'(busy_v[u]), 0);
        model(u, mx, eb, ec, ep);
        chk({tag, " best"},  best_v[u], eb);
        chk({tag, " count"}, cnt_v[u], ec);
        chk({tag, " perm"},  int'(perm_v[u]), int'(ep));
        chk({tag, " W idle"}, w_v[u], 0);
    endtask

    task automatic fill(input int u, input int kind);
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                case (kind)
                    0: tab[u][a][b] = (a == b) ? 7'd0 : 7'd10;
                    1: tab[u][a][b] = 7'(b);
                    2: tab[u][a][b] = 7'($urandom_range(0, 127));
                    3: tab[u][a][b] = 7'($urandom_range(0, 3));
                    4: tab[u][a][b] = 7'd0;
                    5: tab[u][a][b] = 7'd127;
                    default: tab[u][a][b] = 7'd5;
                endcase
            end
        end
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1; start[u] = 1'b0; mode[u] = 1'b0;
            fill(u, 6);
        end
        tick(); tick();
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        chk_reset(0, "reset u2");
        chk_reset(1, "reset u3");
        chk_reset(2, "reset u4");

        // N=3 diagonal table, then maximise via re-Start from DONE.
        fill(1, 0);
        run(1, 1'b0, -1, "diag min");
        run(1, 1'b1, -1, "diag max");
        fill(1, 1);
        run(1, 1'b0, -1, "cost=j");

        // Reset mid-QUERY with Start held high: reset wins and no run starts.
        fill(1, 2);
        mode[1] = 1'b0; start[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        tick(); tick();
        rst[1] = 1'b1; start[1] = 1'b1;
        tick();
        rst[1] = 1'b0; start[1] = 1'b0;
        chk_reset(1, "mid rst");
        tick();
        chk("mid rst stays idle", int'(busy_v[1]), 0);
        run(1, 1'b0, -1, "after rst");

        for (int r = 0; r < 4; r++) begin
            fill(1, (r % 2 == 0) ? 2 : 3);
            run(1, 1'($urandom_range(0, 1)), -1, $sformatf("u3 rand%0d", r));
        end

        // N=2 flat table with a Start pulse while busy.
        fill(0, 6);
        run(0, 1'b0, 2, "n2 flat");
        fill(0, 2);
        run(0, 1'b1, -1, "n2 rand");

        // N=4 with a 4-bit MatchCount: saturation and extreme sums.
        fill(2, 4);
        run(2, 1'b1, -1, "n4 zero max");
        fill(2, 5);
        run(2, 1'b0, 7, "n4 full min");
        for (int r = 0; r < 3; r++) begin
            fill(2, (r == 1) ? 3 : 2);
            run(2, 1'($urandom_range(0, 1)), -1, $sformatf("u4 rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jam_param.md
# jam_param

Parametrised exhaustive job-assignment engine, successor to the fixed 8×8 JAM block. Enumerates all N! worker→job permutations in lexicographic order, fetches each cost from an external combinational cost table via the W/J/Cost port, and keeps the best total, its match count and the first best permutation. Adds a Start/Busy handshake for re-runs without reset and a min/max optimisation mode. Sits next to the cost ROM in the assignment testbench and top level.

## Interface
- N, 8: workers = jobs, legal 2..8.
- CW, 7: Cost width.
- IW, $clog2(N) (min 1): index width, derived.
- SW, CW+IW: sum width; holds N·(2^CW−1).
- MW, 16: MatchCount width; saturating.
- CLK  in  1  clock, rising edge.
- RST  in  1  reset; one clock; reset is synchronous and active-high.
- Start  in  1  launch pulse; honoured only in IDLE or DONE.
- Mode  in  1  0 = minimise, 1 = maximise; sampled with Start.
- W  out  IW  worker index being queried.
- J  out  IW  job assigned to W in the current permutation.
- Cost  in  CW  cost[W][J]; combinational from W/J, same cycle.
- Busy  out  1  high in QUERY or EVAL.
- Valid  out  1  result final; high in DONE.
- BestCost  out  SW  best total so far.
- MatchCount  out  MW  permutations achieving BestCost.
- BestPerm  out  N·IW  first best permutation; job of worker i at [i·IW +: IW].

## Operation
- States: IDLE, QUERY, EVAL, DONE.
- IDLE/DONE + Start → QUERY; perm ← identity, qidx ← 0, sum ← 0, mode_r ← Mode, BestCost ← all-ones (Mode=0) or 0 (Mode=1), MatchCount ← 0, BestPerm ← identity.
- QUERY: W = qidx, J = perm[qidx]; sum ← sum + Cost (zero-extended); qidx increments; qidx = N−1 → EVAL.
- EVAL: sum compared with BestCost. Strictly better (< for min, > for max) → BestCost ← sum, MatchCount ← 1, BestPerm ← perm. Equal → MatchCount + 1, saturating at 2^MW−1; BestPerm unchanged, so it is the lexicographically first optimum. sum ← 0, qidx ← 0.
- EVAL, perm not descending → perm ← next lexicographic permutation, go to QUERY.
- EVAL, perm descending (last) → DONE.
- DONE: results held, Valid = 1 until Start or RST.
- Start while Busy: ignored. Mode outside a Start cycle: ignored.
- Next permutation: pivot = rightmost i with perm[i] < perm[i+1]. Swap with the smallest larger element right of the pivot. Reverse the suffix. Computed combinationally from the registered perm and applied only in EVAL.

## Timing
- Reset values: state IDLE, W=0, J=0, perm identity, Busy=0, Valid=0, BestCost all-ones, MatchCount=0, BestPerm identity, sum=0.
- RST mid-run: reset values on the next edge, no partial results kept; RST has priority over Start.
- Per permutation: N QUERY cycles + 1 EVAL cycle.
- Start sampled at edge k → QUERY, W=0 from edge k. Valid rises at edge k + N!·(N+1) and Busy falls on that same edge.
- W/J are registered and glitch-free. Outside QUERY they show W=0, J=perm[0].
- Cost is sampled at the edge that ends each QUERY cycle; the cost table must settle within one cycle.
- BestCost, MatchCount and BestPerm update only at the EVAL edge, so they are stable during QUERY.
- Re-Start from DONE: Valid drops on the Start edge.

## Structure
- Package jam_pkg: state enum, mode encoding (MODE_MIN=0, MODE_MAX=1), legal-N range check.
- Sub-module jam_next_perm: purely combinational, parametrised by N/IW. Inputs perm; outputs next_perm and is_last. Unit-testable on its own.
- Top holds the FSM, counters, accumulator and compare/update logic.

## Test plan
- N=3, cost = 0 if w==j else 10, Mode=0 → Valid exactly 24 cycles after Start; BestCost=0, MatchCount=1, BestPerm={0,1,2}.
- Same table, Mode=1 via re-Start from DONE without reset → BestCost=30, MatchCount=2 (the two derangements), BestPerm={1,2,0} (first in lex order).
- N=3, cost = j (worker-independent) → every permutation sums 3; MatchCount=6, BestPerm identity.
- N=8, CW=7, contest cost table → BestCost and MatchCount match the golden values; Valid at 40320·9 cycles.
- RST pulsed mid-QUERY, then Start again → all outputs at reset values the next cycle; the rerun gives results identical to a clean run.
- N=2 with cost[0][0]=cost[1][1]=5 and others 5, plus Start pulsed while Busy → MatchCount=2, BestCost=10, 6-cycle latency, and the mid-run Start has no effect.
